// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate sequencer: FSM state encoding, activation
// mode codes and constant-function helpers for address/accumulator widths.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWEEP_X = 2'd1,
    SWEEP_Y = 2'd2,
    FINISH  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ACT_LIN   = 2'd0,
    ACT_HSIG  = 2'd1,
    ACT_HTANH = 2'd2,
    ACT_LIN3  = 2'd3
  } act_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Address width, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/gate_act.sv
// One row of the gate output stage (purely combinational):
//   acc  : full-precision dot-product accumulator (Q.2*QM)
//   bias : row bias in the BW-bit Q(QN).(QM) format
//   mode : activation select
//   y    : rounded, saturated and activated BW-bit result
module gate_act
  import gate_seq_pkg::*;
#(
  parameter int BW    = 18,
  parameter int QM    = 11,
  parameter int ACC_W = 39
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [BW-1:0]    bias,
  input  act_e                    mode,
  output logic signed [BW-1:0]    y
);

  // One guard bit above the accumulator absorbs bias and rounding terms.
  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] MAXV = (SW'(1) << (BW-1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  localparam logic signed [BW:0]   ONE  = (BW+1)'(1) << QM;
  localparam logic signed [BW:0]   NONE = -ONE;
  localparam logic signed [BW:0]   HALF = ONE >>> 1;

  logic signed [SW-1:0] acc_x, bias_x, sum, shr;
  logic signed [BW-1:0] v;
  logic signed [BW:0]   vx, q, hs;

  assign acc_x  = {acc[ACC_W-1], acc};
  // Bias aligned to the product scale (shifted left by QM).
  assign bias_x = {{(SW-BW-QM){bias[BW-1]}}, bias, {QM{1'b0}}};
  assign sum    = acc_x + bias_x + (SW'(1) << (QM-1));
  assign shr    = sum >>> QM;

  always_comb begin
    if (shr > MAXV)      v = MAXV[BW-1:0];
    else if (shr < MINV) v = MINV[BW-1:0];
    else                 v = shr[BW-1:0];
  end

  assign vx = {v[BW-1], v};
  assign q  = vx >>> 2;
  assign hs = q + HALF;

  always_comb begin
    y = v;
    case (mode)
      ACT_HSIG: begin
        if (hs[BW])        y = '0;
        else if (hs > ONE) y = ONE[BW-1:0];
        else               y = hs[BW-1:0];
      end
      ACT_HTANH: begin
        if (vx > ONE)       y = ONE[BW-1:0];
        else if (vx < NONE) y = NONE[BW-1:0];
        else                y = v;
      end
      default: y = v;
    endcase
  end

endmodule

// File: rtl/gate_seq.sv
// Gate sequencer: sweeps the X then Y weight columns, accumulating one
// weight*element product per row per cycle, then rounds/saturates/activates
// every row and presents the result with a one-cycle dataReady_gate pulse.
// Ports:
//   clock, reset (async, active low)
//   beginCalc, act_mode            : start request / activation select
//   inputVec, prevLayerOut         : element at colAddress_X / colAddress_Y
//   weightMem_X, weightMem_Y       : weight column for current address
//   biasVec                        : per-row bias
//   colAddress_X, colAddress_Y     : column indices
//   busy, dataReady_gate, gateOutput
module gate_seq
  import gate_seq_pkg::*;
#(
  parameter int INPUT_SZ  = 2,
  parameter int HIDDEN_SZ = 16,
  parameter int QN        = 6,
  parameter int QM        = 11,
  parameter int BITWIDTH  = QN + QM + 1,
  parameter int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          beginCalc,
  input  logic [1:0]                    act_mode,
  input  logic [BITWIDTH-1:0]           inputVec,
  input  logic [BITWIDTH-1:0]           prevLayerOut,
  input  logic [LAYER_BITWIDTH-1:0]     weightMem_X,
  input  logic [LAYER_BITWIDTH-1:0]     weightMem_Y,
  input  logic [LAYER_BITWIDTH-1:0]     biasVec,
  output logic [addr_w(INPUT_SZ)-1:0]   colAddress_X,
  output logic [addr_w(HIDDEN_SZ)-1:0]  colAddress_Y,
  output logic                          busy,
  output logic                          dataReady_gate,
  output logic [LAYER_BITWIDTH-1:0]     gateOutput
);

  localparam int BW    = BITWIDTH;
  localparam int AX    = addr_w(INPUT_SZ);
  localparam int AY    = addr_w(HIDDEN_SZ);
  localparam int ACC_W = 2*BW + clog2(INPUT_SZ + HIDDEN_SZ + 1);

  state_e state_q, state_d;
  act_e   mode_q;
  logic   start;

  assign start = (state_q == IDLE) && beginCalc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beginCalc) state_d = SWEEP_X;
      SWEEP_X: if (colAddress_X == AX'(INPUT_SZ-1))  state_d = SWEEP_Y;
      SWEEP_Y: if (colAddress_Y == AY'(HIDDEN_SZ-1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      mode_q         <= ACT_LIN;
      busy           <= 1'b0;
      dataReady_gate <= 1'b0;
      colAddress_X   <= '0;
      colAddress_Y   <= '0;
    end else begin
      state_q        <= state_d;
      busy           <= (state_d != IDLE);
      dataReady_gate <= (state_q == FINISH);
      if (start) mode_q <= act_e'(act_mode);
      // Counters wrap to 0 on their last column, so the idle column always
      // reads 0 while the other side sweeps.
      if (start)
        colAddress_X <= '0;
      else if (state_q == SWEEP_X)
        colAddress_X <= (colAddress_X == AX'(INPUT_SZ-1)) ? '0 : colAddress_X + 1'b1;
      if (start)
        colAddress_Y <= '0;
      else if (state_q == SWEEP_Y)
        colAddress_Y <= (colAddress_Y == AY'(HIDDEN_SZ-1)) ? '0 : colAddress_Y + 1'b1;
    end
  end

  logic signed [2*BW-1:0] x_e, h_e;
  assign x_e = {{BW{inputVec[BW-1]}}, inputVec};
  assign h_e = {{BW{prevLayerOut[BW-1]}}, prevLayerOut};

  for (genvar r = 0; r < HIDDEN_SZ; r++) begin : g_row
    logic signed [BW-1:0]    wx, wy, b, act, gq;
    logic signed [2*BW-1:0]  wx_e, wy_e, prod;
    logic signed [ACC_W-1:0] acc;

    assign wx   = weightMem_X[r*BW +: BW];
    assign wy   = weightMem_Y[r*BW +: BW];
    assign b    = biasVec[r*BW +: BW];
    assign wx_e = {{BW{wx[BW-1]}}, wx};
    assign wy_e = {{BW{wy[BW-1]}}, wy};

    always_comb begin
      prod = '0;
      if (state_q == SWEEP_X)      prod = wx_e * x_e;
      else if (state_q == SWEEP_Y) prod = wy_e * h_e;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)     acc <= '0;
      else if (start) acc <= '0;
      else if (state_q == SWEEP_X || state_q == SWEEP_Y)
        acc <= acc + {{(ACC_W-2*BW){prod[2*BW-1]}}, prod};
    end

    gate_act #(.BW(BW), .QM(QM), .ACC_W(ACC_W)) u_act (
      .acc  (acc),
      .bias (b),
      .mode (mode_q),
      .y    (act)
    );

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)                 gq <= '0;
      else if (state_q == FINISH) gq <= act;
    end

    assign gateOutput[r*BW +: BW] = gq;
  end

endmodule
